// File: rtl/pipe_test_pkg.sv
// Shared definitions for the pipeline consumer/checker slice.
//   DEFAULT_DATA_W : default sample width used by the checker modules
//   LFSR_TAPS      : feedback tap mask for the 16-bit stall LFSR (x^16+x^14+x^13+x^11+1)
//   chk_state_t    : sequence checker state encoding
//   lfsr_seed_fix  : maps an all-zero seed (LFSR lock-up state) to 16'h0001
package pipe_test_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  // Bits 15, 13, 12, 10 correspond to taps 16, 14, 13, 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } chk_state_t;

  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/stream_checker.sv
// One stream of the pipeline consumer: LFSR-driven backpressure with a
// bounded stall run, a +1 sequence checker and saturating counters.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_data         : sample from the pipeline under test
//   in_valid        : sample valid
//   in_flush        : drop the checker back to UNSYNC, ignoring this sample
//   stall_enable    : global enable for stall generation
//   out_stall       : registered backpressure to the pipeline
//   accept_count    : accepted samples, saturating
//   error_count     : sequence errors, saturating
//   error_flag      : sticky, set on the first sequence error
module stream_checker
  import pipe_test_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ERR_W        = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  STALL_THRESH = 8'd64,
  parameter int unsigned MAX_STALL    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_flush,
  input  logic              stall_enable,
  output logic              out_stall,
  output logic [CNT_W-1:0]  accept_count,
  output logic [ERR_W-1:0]  error_count,
  output logic              error_flag
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [15:0]       lfsr;
  logic [RUN_W-1:0]  run;
  chk_state_t        state;
  logic [DATA_W-1:0] exp_data;

  logic stall_req_p0;
  logic stall_next_p0;
  logic accept_p0;
  logic mismatch_p0;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: combinational decode against the current registered state
  assign stall_req_p0  = stall_enable && (lfsr[7:0] < STALL_THRESH);
  // run holds how many consecutive cycles out_stall has been high, including
  // the present one, so the limit check releases after exactly MAX_STALL.
  assign stall_next_p0 = stall_req_p0 && (run < RUN_MAX);
  assign accept_p0     = in_valid && !out_stall && !in_flush;
  assign mismatch_p0   = (state == SYNC) && (in_data != exp_data);

  // Stage p1: registered stall, checker state and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr         <= lfsr_seed_fix(LFSR_SEED);
      run          <= '0;
      out_stall    <= 1'b0;
      state        <= UNSYNC;
      exp_data     <= '0;
      accept_count <= '0;
      error_count  <= '0;
      error_flag   <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      out_stall <= stall_next_p0;
      run       <= stall_next_p0 ? run + 1'b1 : '0;

      if (in_flush) begin
        state <= UNSYNC;
      end else if (accept_p0) begin
        state        <= SYNC;
        exp_data     <= in_data + 1'b1;
        accept_count <= sat_inc_cnt(accept_count);
        if (mismatch_p0) begin
          error_count <= sat_inc_err(error_count);
          error_flag  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_consumer_checker.sv
// Downstream sink for the two test pipelines. Each stream gets independent
// backpressure and +1 sequence checking; this level is wiring only.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   in_data_n, in_valid_n, in_flush_n  : stream n sample, valid and flush
//   stall_enable                       : global enable for stall generation
//   out_stall_n                        : registered backpressure to stream n
//   accept_count_n, error_count_n      : saturating counters per stream
//   error_flag_n                       : sticky sequence-error flag per stream
module pipe_consumer_checker
  import pipe_test_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ERR_W        = 8,
  parameter logic [15:0] LFSR_SEED_1  = 16'hACE1,
  parameter logic [15:0] LFSR_SEED_2  = 16'h1D2B,
  parameter logic [7:0]  STALL_THRESH = 8'd64,
  parameter int unsigned MAX_STALL    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  input  logic              in_flush_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  input  logic              in_flush_2,
  input  logic              stall_enable,
  output logic              out_stall_1,
  output logic              out_stall_2,
  output logic [CNT_W-1:0]  accept_count_1,
  output logic [CNT_W-1:0]  accept_count_2,
  output logic [ERR_W-1:0]  error_count_1,
  output logic [ERR_W-1:0]  error_count_2,
  output logic              error_flag_1,
  output logic              error_flag_2
);

  stream_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W), .LFSR_SEED(LFSR_SEED_1),
    .STALL_THRESH(STALL_THRESH), .MAX_STALL(MAX_STALL)
  ) u_stream_1 (
    .clk(clk), .reset(reset),
    .in_data(in_data_1), .in_valid(in_valid_1), .in_flush(in_flush_1),
    .stall_enable(stall_enable), .out_stall(out_stall_1),
    .accept_count(accept_count_1), .error_count(error_count_1),
    .error_flag(error_flag_1)
  );

  stream_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W), .LFSR_SEED(LFSR_SEED_2),
    .STALL_THRESH(STALL_THRESH), .MAX_STALL(MAX_STALL)
  ) u_stream_2 (
    .clk(clk), .reset(reset),
    .in_data(in_data_2), .in_valid(in_valid_2), .in_flush(in_flush_2),
    .stall_enable(stall_enable), .out_stall(out_stall_2),
    .accept_count(accept_count_2), .error_count(error_count_2),
    .error_flag(error_flag_2)
  );

endmodule

// File: tb/tb_pipe_consumer_checker.sv
module tb_pipe_consumer_checker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data_1, in_data_2;
  logic              in_valid_1, in_valid_2, in_flush_1, in_flush_2;
  logic              stall_enable;
  logic              out_stall_1, out_stall_2;
  logic [CNT_W-1:0]  accept_count_1, accept_count_2;
  logic [ERR_W-1:0]  error_count_1, error_count_2;
  logic              error_flag_1, error_flag_2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_consumer_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W),
    .STALL_THRESH(8'hFF), .MAX_STALL(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data_1(in_data_1), .in_valid_1(in_valid_1), .in_flush_1(in_flush_1),
    .in_data_2(in_data_2), .in_valid_2(in_valid_2), .in_flush_2(in_flush_2),
    .stall_enable(stall_enable),
    .out_stall_1(out_stall_1), .out_stall_2(out_stall_2),
    .accept_count_1(accept_count_1), .accept_count_2(accept_count_2),
    .error_count_1(error_count_1), .error_count_2(error_count_2),
    .error_flag_1(error_flag_1), .error_flag_2(error_flag_2)
  );

  typedef struct {
    logic        v1; logic [31:0] d1; logic f1;
    logic        v2; logic [31:0] d2; logic f2;
    int          a1; int e1; logic g1;
    int          a2; int e2; logic g2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v1, input logic [31:0] d1, input logic f1,
                     input logic v2, input logic [31:0] d2, input logic f2,
                     input int a1, input int e1, input logic g1,
                     input int a2, input int e2, input logic g2);
    vec_t t;
    t.v1 = v1; t.d1 = d1; t.f1 = f1;
    t.v2 = v2; t.d2 = d2; t.f2 = f2;
    t.a1 = a1; t.e1 = e1; t.g1 = g1;
    t.a2 = a2; t.e2 = e2; t.g2 = g2;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " out_stall_1"}, 32'(out_stall_1), 0);
    chk({tag, " out_stall_2"}, 32'(out_stall_2), 0);
    chk({tag, " accept_count_1"}, 32'(accept_count_1), 0);
    chk({tag, " accept_count_2"}, 32'(accept_count_2), 0);
    chk({tag, " error_count_1"}, 32'(error_count_1), 0);
    chk({tag, " error_count_2"}, 32'(error_count_2), 0);
    chk({tag, " error_flag_1"}, 32'(error_flag_1), 0);
    chk({tag, " error_flag_2"}, 32'(error_flag_2), 0);
  endtask

  initial begin
    int run1, run2, max1, max2;
    bit found, accepted;

    reset = 1'b1;
    in_data_1 = '0; in_valid_1 = 1'b0; in_flush_1 = 1'b0;
    in_data_2 = '0; in_valid_2 = 1'b0; in_flush_2 = 1'b0;
    stall_enable = 1'b0;

    // Stream 1: +1 run, then error/resync, then wrap and saturation.
    // Stream 2: flush with valid ignored, then re-sync.
    add(1, 5, 0,  0, 0, 0,   1, 0, 0,  0, 0, 0);
    add(1, 6, 0,  0, 0, 0,   2, 0, 0,  0, 0, 0);
    add(1, 7, 0,  0, 0, 0,   3, 0, 0,  0, 0, 0);
    add(1, 8, 0,  0, 0, 0,   4, 0, 0,  0, 0, 0);
    add(0, 0, 1,  0, 0, 0,   4, 0, 0,  0, 0, 0);
    add(1, 10, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0);
    add(1, 11, 0, 0, 0, 0,   6, 0, 0,  0, 0, 0);
    add(1, 13, 0, 0, 0, 0,   7, 1, 1,  0, 0, 0);
    add(1, 14, 0, 0, 0, 0,   8, 1, 1,  0, 0, 0);
    add(0, 0, 0,  1, 20, 0,  8, 1, 1,  1, 0, 0);
    add(0, 0, 0,  1, 21, 0,  8, 1, 1,  2, 0, 0);
    add(0, 0, 0,  1, 99, 1,  8, 1, 1,  2, 0, 0);
    add(0, 0, 0,  1, 100, 0, 8, 1, 1,  3, 0, 0);
    add(0, 0, 0,  1, 101, 0, 8, 1, 1,  4, 0, 0);
    add(0, 0, 1,  0, 0, 0,   8, 1, 1,  4, 0, 0);
    add(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 9, 1, 1, 4, 0, 0);
    add(1, 32'h0000_0000, 0, 0, 0, 0, 10, 1, 1, 4, 0, 0);
    add(1, 5, 0,  0, 0, 0,   11, 2, 1, 4, 0, 0);
    add(1, 5, 0,  0, 0, 0,   12, 3, 1, 4, 0, 0);
    add(1, 5, 0,  0, 0, 0,   13, 3, 1, 4, 0, 0);
    add(1, 5, 0,  0, 0, 0,   14, 3, 1, 4, 0, 0);
    add(1, 5, 0,  0, 0, 0,   15, 3, 1, 4, 0, 0);
    add(1, 5, 1,  0, 0, 0,   15, 3, 1, 4, 0, 0);
    add(0, 5, 0,  0, 0, 0,   15, 3, 1, 4, 0, 0);
    add(1, 6, 0,  1, 102, 0, 16, 3, 1, 5, 0, 0);

    #2;
    all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    all_zero("post_reset_idle");

    foreach (vecs[i]) begin
      in_valid_1 = vecs[i].v1; in_data_1 = vecs[i].d1; in_flush_1 = vecs[i].f1;
      in_valid_2 = vecs[i].v2; in_data_2 = vecs[i].d2; in_flush_2 = vecs[i].f2;
      step();
      chk($sformatf("vec%0d accept_count_1", i), 32'(accept_count_1), vecs[i].a1);
      chk($sformatf("vec%0d error_count_1", i), 32'(error_count_1), vecs[i].e1);
      chk($sformatf("vec%0d error_flag_1", i), 32'(error_flag_1), 32'(vecs[i].g1));
      chk($sformatf("vec%0d accept_count_2", i), 32'(accept_count_2), vecs[i].a2);
      chk($sformatf("vec%0d error_count_2", i), 32'(error_count_2), vecs[i].e2);
      chk($sformatf("vec%0d error_flag_2", i), 32'(error_flag_2), 32'(vecs[i].g2));
      chk($sformatf("vec%0d out_stall_1", i), 32'(out_stall_1), 0);
      chk($sformatf("vec%0d out_stall_2", i), 32'(out_stall_2), 0);
    end
    in_valid_1 = 1'b0; in_flush_1 = 1'b0;
    in_valid_2 = 1'b0; in_flush_2 = 1'b0;

    // Stall runs bounded at MAX_STALL with a near-always request.
    stall_enable = 1'b1;
    run1 = 0; run2 = 0; max1 = 0; max2 = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      run1 = out_stall_1 ? run1 + 1 : 0;
      run2 = out_stall_2 ? run2 + 1 : 0;
      if (run1 > max1) max1 = run1;
      if (run2 > max2) max2 = run2;
    end
    chk("max_stall_run_1", max1, 4);
    chk("max_stall_run_2", max2, 4);
    chk("stall_no_accept_1", 32'(accept_count_1), 16);

    // Valid 50 held across a stall is accepted exactly once.
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_stall_1) found = 1;
      else step();
    end
    chk("stall_seen_before_hold", 32'(found), 1);
    in_valid_1 = 1'b1; in_data_1 = 50;
    step();
    chk("held_during_stall", 32'(accept_count_1), 16);
    accepted = 0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      if (!out_stall_1) accepted = 1;
      step();
    end
    in_valid_1 = 1'b0;
    chk("held_release_seen", 32'(accepted), 1);
    chk("held_accept_once", 32'(accept_count_1), 17);
    step();
    step();
    chk("held_no_extra", 32'(accept_count_1), 17);

    // Asynchronous reset mid-stream while stall is high.
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_stall_1) found = 1;
      else step();
    end
    chk("stall_seen_before_reset", 32'(found), 1);
    #2 reset = 1'b1;
    #1 all_zero("async_reset");
    stall_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_valid_1 = 1'b1; in_data_1 = 77;
    step();
    chk("post_reset_77 accept_count_1", 32'(accept_count_1), 1);
    chk("post_reset_77 error_count_1", 32'(error_count_1), 0);
    in_data_1 = 78;
    step();
    in_valid_1 = 1'b0;
    chk("post_reset_78 accept_count_1", 32'(accept_count_1), 2);
    chk("post_reset_78 error_count_1", 32'(error_count_1), 0);
    chk("post_reset_78 error_flag_1", 32'(error_flag_1), 0);
    chk("post_reset accept_count_2", 32'(accept_count_2), 0);
    chk("post_reset out_stall_1", 32'(out_stall_1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
